// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: recovers line/frame timing from the sampled
// bus, locks onto nominal timing and regenerates pixel coordinates and colour.
module vga_sync_monitor #(
  parameter int unsigned CLKS_PER_PIXEL = 2,
  parameter int unsigned H_TOTAL        = 800,
  parameter int unsigned H_SYNC         = 96,
  parameter int unsigned H_BACK         = 48,
  parameter int unsigned H_ACTIVE       = 640,
  parameter int unsigned V_TOTAL        = 525,
  parameter int unsigned V_SYNC         = 2,
  parameter int unsigned V_BACK         = 33,
  parameter int unsigned V_ACTIVE       = 480,
  parameter logic        SYNC_ACTIVE    = 1'b0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [4:0]  iVGA,
  output logic        oLocked,
  output logic        oPixelValid,
  output logic [9:0]  oX,
  output logic [9:0]  oY,
  output logic [2:0]  oRGB,
  output logic        oFrameDone,
  output logic [19:0] oLitCount,
  output logic        oError,
  output logic [7:0]  oErrCount
);

  localparam int unsigned DW = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
  localparam int unsigned TW = $clog2(2 * H_TOTAL + 1);

  localparam logic [DW-1:0] DIV_LAST    = DW'(CLKS_PER_PIXEL - 1);
  localparam logic [10:0]   H_LAST      = 11'(H_TOTAL - 1);
  localparam logic [10:0]   H_SYNC_LAST = 11'(H_SYNC - 1);
  localparam logic [10:0]   H_VIS_LO    = 11'(H_SYNC + H_BACK);
  localparam logic [10:0]   H_VIS_HI    = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]    V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0]    V_SYNC_LAST = 10'(V_SYNC - 1);
  localparam logic [9:0]    V_VIS_LO    = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]    V_VIS_HI    = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [TW-1:0] TMO_LIMIT   = TW'(2 * H_TOTAL);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] ALIGN  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [4:0]    vga_q;
  logic [1:0]    sync_qq;
  logic [DW-1:0] div_q, div_now, div_d;
  logic [10:0]   hcnt_q, hcnt_d;
  logic [9:0]    vcnt_q, vcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    state_q, state_d;
  logic          dirty_q, dirty_d;
  logic [19:0]   lit_q, lit_d;
  logic          strobe, timeout, mismatch, count_err, vis;
  logic          locked_d, pv_d, done_d, err_d;
  logic [9:0]    x_d, y_d;
  logic [2:0]    rgb_d;
  logic [19:0]   litout_d;
  logic [7:0]    errcnt_d;

  // Sync edges from the registered sample against its previous value
  logic hs_now, hs_prev, vs_now, vs_prev, h_rise, h_fall, v_rise, v_fall;
  assign hs_now  = (vga_q[1] == SYNC_ACTIVE);
  assign vs_now  = (vga_q[0] == SYNC_ACTIVE);
  assign hs_prev = (sync_qq[1] == SYNC_ACTIVE);
  assign vs_prev = (sync_qq[0] == SYNC_ACTIVE);
  assign h_rise  = hs_now & ~hs_prev;
  assign h_fall  = ~hs_now & hs_prev;
  assign v_rise  = vs_now & ~vs_prev;
  assign v_fall  = ~vs_now & vs_prev;

  // Counters, checks and next-state logic
  always_comb begin
    div_now  = h_rise ? '0 : div_q;
    strobe   = (div_now == '0);
    div_d    = (div_now == DIV_LAST) ? '0 : DW'(div_now + 1'b1);
    hcnt_d   = h_rise ? 11'd0 : ((strobe && hcnt_q != 11'h7FF) ? hcnt_q + 11'd1 : hcnt_q);
    vcnt_d   = v_rise ? 10'd0 : ((h_rise && vcnt_q != 10'h3FF) ? vcnt_q + 10'd1 : vcnt_q);
    tmo_d    = h_rise ? '0 : ((strobe && tmo_q != TMO_LIMIT) ? TW'(tmo_q + 1'b1) : tmo_q);
    timeout  = (tmo_d == TMO_LIMIT) && (tmo_q != TMO_LIMIT);
    mismatch = (h_rise && hcnt_q != H_LAST) || (h_fall && hcnt_q != H_SYNC_LAST) ||
               (v_rise && vcnt_q != V_LAST) || (v_fall && vcnt_q != V_SYNC_LAST);
    vis      = (hcnt_d >= H_VIS_LO) && (hcnt_d < H_VIS_HI) &&
               (vcnt_d >= V_VIS_LO) && (vcnt_d < V_VIS_HI);

    state_d   = state_q;
    dirty_d   = dirty_q;
    count_err = 1'b0;
    err_d     = 1'b0;
    done_d    = 1'b0;
    pv_d      = 1'b0;
    x_d       = oX;
    y_d       = oY;
    rgb_d     = oRGB;
    litout_d  = oLitCount;
    errcnt_d  = oErrCount;

    case (state_q)
      SEARCH: begin
        if (v_rise) begin
          state_d = ALIGN;
          dirty_d = 1'b0;
        end
      end
      ALIGN: begin
        count_err = mismatch;
        if (v_rise) begin
          // Checks on this clock still belong to the frame that is ending
          if (!dirty_q && !mismatch) state_d = LOCKED;
          dirty_d = 1'b0;
        end else if (mismatch) begin
          dirty_d = 1'b1;
        end
      end
      LOCKED: begin
        if (mismatch) begin
          count_err = 1'b1;
          err_d     = 1'b1;
          state_d   = ALIGN;
          dirty_d   = 1'b1;
        end else begin
          if (v_rise) begin
            done_d   = 1'b1;
            litout_d = lit_q;
          end
          if (strobe && vis) begin
            pv_d  = 1'b1;
            x_d   = 10'(hcnt_d - H_VIS_LO);
            y_d   = vcnt_d - V_VIS_LO;
            rgb_d = vga_q[4:2];
          end
        end
      end
      default: state_d = SEARCH;
    endcase

    if (timeout) begin
      state_d = SEARCH;
      pv_d    = 1'b0;
      done_d  = 1'b0;
    end

    if (count_err && oErrCount != 8'hFF) errcnt_d = oErrCount + 8'd1;

    if (state_d != LOCKED || done_d)      lit_d = 20'd0;
    else if (oPixelValid && oRGB != 3'd0) lit_d = lit_q + 20'd1;
    else                                  lit_d = lit_q;

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      vga_q       <= '0;
      sync_qq     <= '0;
      div_q       <= '0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      tmo_q       <= '0;
      state_q     <= SEARCH;
      dirty_q     <= 1'b0;
      lit_q       <= '0;
      oLocked     <= 1'b0;
      oPixelValid <= 1'b0;
      oX          <= '0;
      oY          <= '0;
      oRGB        <= '0;
      oFrameDone  <= 1'b0;
      oLitCount   <= '0;
      oError      <= 1'b0;
      oErrCount   <= '0;
    end else begin
      vga_q       <= iVGA;
      sync_qq     <= vga_q[1:0];
      div_q       <= div_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      tmo_q       <= tmo_d;
      state_q     <= state_d;
      dirty_q     <= dirty_d;
      lit_q       <= lit_d;
      oLocked     <= locked_d;
      oPixelValid <= pv_d;
      oX          <= x_d;
      oY          <= y_d;
      oRGB        <= rgb_d;
      oFrameDone  <= done_d;
      oLitCount   <= litout_d;
      oError      <= err_d;
      oErrCount   <= errcnt_d;
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboard bench for vga_sync_monitor on a reduced 6x4 visible raster
// (10 pixels x 8 lines total, 2 clocks per pixel).
module tb_vga_sync_monitor;

  localparam int CPP = 2;
  localparam int HT = 10, HS = 2, HB = 1, HA = 6;
  localparam int VT = 8,  VS = 2, VB = 1, VA = 4;
  localparam logic SA = 1'b0;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] rgb;
  } px_t;

  logic        clk;
  logic        rst;
  logic [4:0]  vga;
  logic        oLocked, oPixelValid, oFrameDone, oError;
  logic [9:0]  oX, oY;
  logic [2:0]  oRGB;
  logic [19:0] oLitCount;
  logic [7:0]  oErrCount;

  px_t px_q[$];
  int  lit_q[$];
  int  err_q[$];
  px_t exp_px;
  int  n_vec = 0;
  int  n_err = 0;
  bit  first_driven = 0, seen_valid = 0, watch = 0, locked_seen = 0;
  time t_drive = 0, t_valid = 0;

  vga_sync_monitor #(
    .CLKS_PER_PIXEL(CPP), .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .SYNC_ACTIVE(SA)
  ) dut (
    .Clock(clk), .Reset(rst), .iVGA(vga),
    .oLocked(oLocked), .oPixelValid(oPixelValid), .oX(oX), .oY(oY), .oRGB(oRGB),
    .oFrameDone(oFrameDone), .oLitCount(oLitCount), .oError(oError), .oErrCount(oErrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] pat_rgb(input int pat, input int x, input int y);
    case (pat)
      0:       return 3'((x + y) % 8);
      1:       return 3'd7;
      2:       return ((x + y) % 2 != 0) ? 3'd7 : 3'd0;
      default: return 3'd0;
    endcase
  endfunction

  task automatic put_px(input logic [4:0] v);
    vga = v;
    repeat (CPP) @(negedge clk);
  endtask

  // One frame from first_line; pixels on lines <= px_upto are expected out
  task automatic gen_frame(input int first_line, input int pat, input int px_upto,
                           input bit push_lit, input int bad_line, input int vs_w);
    int lit = 0;
    for (int l = first_line; l < VT; l++) begin
      for (int p = 0; p < HT + ((l == bad_line) ? 1 : 0); p++) begin
        logic hs, vs;
        logic [2:0] rgb;
        bit vis;
        px_t e;
        hs  = (p < HS) ? SA : ~SA;
        vs  = (l < vs_w) ? SA : ~SA;
        vis = (p >= HS + HB) && (p < HS + HB + HA) && (l >= VS + VB) && (l < VS + VB + VA);
        rgb = vis ? pat_rgb(pat, p - (HS + HB), l - (VS + VB)) : 3'd0;
        if (vis && l <= px_upto) begin
          e.x = 10'(p - (HS + HB));
          e.y = 10'(l - (VS + VB));
          e.rgb = rgb;
          px_q.push_back(e);
          if (rgb != 3'd0) lit++;
          if (!first_driven) begin
            first_driven = 1;
            t_drive = $time;
          end
        end
        put_px({rgb, hs, vs});
      end
    end
    if (push_lit) lit_q.push_back(lit);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event
  always @(negedge clk) begin
    if (!rst) begin
      if (oPixelValid) begin
        if (!seen_valid) begin
          seen_valid = 1;
          t_valid = $time;
        end
        if (px_q.size() == 0) check("unexpected_pixel_valid", 1, 0);
        else begin
          exp_px = px_q.pop_front();
          check("pixel_x", int'(oX), int'(exp_px.x));
          check("pixel_y", int'(oY), int'(exp_px.y));
          check("pixel_rgb", int'(oRGB), int'(exp_px.rgb));
        end
      end
      if (oFrameDone) begin
        if (lit_q.size() == 0) check("unexpected_frame_done", 1, 0);
        else check("lit_count", int'(oLitCount), lit_q.pop_front());
      end
      if (oError) begin
        if (err_q.size() == 0) check("unexpected_error", 1, 0);
        else check("err_count_at_error", int'(oErrCount), err_q.pop_front());
      end
      if (watch && oLocked) locked_seen = 1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    vga = 5'd0;
    repeat (5) begin
      vga = 5'($urandom);
      @(negedge clk);
    end
    check("reset_locked", int'(oLocked), 0);
    check("reset_pixel_valid", int'(oPixelValid), 0);
    check("reset_x", int'(oX), 0);
    check("reset_y", int'(oY), 0);
    check("reset_rgb", int'(oRGB), 0);
    check("reset_frame_done", int'(oFrameDone), 0);
    check("reset_lit_count", int'(oLitCount), 0);
    check("reset_error", int'(oError), 0);
    check("reset_err_count", int'(oErrCount), 0);
    rst = 1'b0;

    gen_frame(4, 0, -1, 0, -1, VS);
    check("locked_after_partial", int'(oLocked), 0);
    gen_frame(0, 0, -1, 0, -1, VS);
    check("locked_after_align_frame", int'(oLocked), 0);
    gen_frame(0, 0, VT, 1, -1, VS);
    check("locked_in_first_locked_frame", int'(oLocked), 1);
    gen_frame(0, 1, VT, 1, -1, VS);
    gen_frame(0, 2, VT, 1, -1, VS);
    gen_frame(0, 3, VT, 1, -1, VS);

    // Line 4 is one pixel long; caught at the start of line 5
    err_q.push_back(1);
    gen_frame(0, 1, 4, 0, 4, VS);
    check("locked_after_long_line", int'(oLocked), 0);
    check("err_count_after_long_line", int'(oErrCount), 1);
    gen_frame(0, 1, -1, 0, -1, VS);
    check("locked_during_clean_align", int'(oLocked), 0);
    gen_frame(0, 1, VT, 0, -1, VS);
    check("relocked", int'(oLocked), 1);

    // Hsync stops: last assert edge was at the start of line 7
    vga = {3'b000, ~SA, ~SA};
    repeat (21) @(negedge clk);
    check("locked_before_timeout", int'(oLocked), 1);
    @(negedge clk);
    check("locked_after_timeout", int'(oLocked), 0);
    check("err_count_after_timeout", int'(oErrCount), 1);
    repeat (10) @(negedge clk);

    gen_frame(0, 0, -1, 0, -1, VS);
    check("locked_after_search_align", int'(oLocked), 0);
    gen_frame(0, 1, VT, 1, -1, VS);
    check("locked_before_bad_vsync", int'(oLocked), 1);

    // Persistent 3-line vsync: one mismatch per frame
    err_q.push_back(2);
    gen_frame(0, 0, -1, 0, -1, 3);
    check("locked_after_bad_vsync", int'(oLocked), 0);
    watch = 1;
    repeat (99) gen_frame(0, 0, -1, 0, -1, 3);
    check("err_count_after_100_bad", int'(oErrCount), 101);
    repeat (156) gen_frame(0, 0, -1, 0, -1, 3);
    check("err_count_saturated", int'(oErrCount), 255);
    check("never_locked_bad_vsync", int'(locked_seen), 0);

    vga = {3'b000, ~SA, ~SA};
    repeat (20) @(negedge clk);
    check("pixels_outstanding", px_q.size(), 0);
    check("frames_outstanding", lit_q.size(), 0);
    check("errors_outstanding", err_q.size(), 0);
    check("first_pixel_latency", int'(t_valid - t_drive), 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA output generator: samples the 5-bit VGA bus, recovers line and frame timing, checks it against nominal 640x480 timing, and regenerates pixel coordinates and colour.
- Used in benches and on-chip self-check to verify video output cycle-accurately, downstream of the display logic.
- Same clock domain as the generator; no synchronizers.

Parameters:
- CLKS_PER_PIXEL, 2, Clock cycles per pixel.
- H_TOTAL, 800, pixels per line.
- H_SYNC, 96, hsync width in pixels.
- H_BACK, 48, back porch in pixels.
- H_ACTIVE, 640, visible pixels per line.
- V_TOTAL, 525, lines per frame.
- V_SYNC, 2, vsync width in lines.
- V_BACK, 33, vertical back porch in lines.
- V_ACTIVE, 480, visible lines.
- SYNC_ACTIVE, 0, asserted level of both syncs (0 = active low).

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- iVGA  in  5  [4]=R, [3]=G, [2]=B, [1]=HSync, [0]=VSync.
- oLocked  out  1  timing matches parameters.
- oPixelValid  out  1  oX/oY/oRGB describe a visible pixel.
- oX  out  10  visible column 0..H_ACTIVE-1.
- oY  out  10  visible row 0..V_ACTIVE-1.
- oRGB  out  3  {R,G,B} of the pixel.
- oFrameDone  out  1  one-clock pulse at each frame boundary while locked.
- oLitCount  out  20  non-black visible pixels in the last complete frame.
- oError  out  1  one-clock pulse on a timing mismatch.
- oErrCount  out  8  saturating mismatch count.

Behaviour:
- Reset: every output is 0; state is SEARCH; all counters are 0.
- Input stage:
  - iVGA is registered once.
  - Assert and deassert edges of each sync are detected by comparing the registered sample with its previous value.
- Pixel strobe:
  - A divider counts modulo CLKS_PER_PIXEL.
  - The divider is forced to 0 on the clock where the hsync assert edge is detected. That clock is pixel 0 of the line.
- hcnt (11 bits):
  - Set to 0 at the hsync assert edge.
  - +1 per strobe after that, saturating at 2047.
- Line checks (at each hsync assert edge):
  - Line length: the previous line's hcnt must equal H_TOTAL-1.
  - Sync width: at the hsync deassert edge, hcnt must equal H_SYNC-1.
- vcnt (10 bits):
  - Set to 0 at the vsync assert edge.
  - +1 at each hsync assert edge otherwise.
- Frame checks (at each vsync assert edge):
  - Frame length: the previous vcnt must equal V_TOTAL-1.
  - Vsync width: at the vsync deassert edge, vcnt must equal V_SYNC-1.
- States:
  - SEARCH: wait for a vsync assert edge, then go to ALIGN.
  - ALIGN: check one full frame, up to the next vsync assert edge.
    - Any mismatch: oErrCount increments and the state stays ALIGN, restarting at the next vsync assert edge.
    - Clean frame: go to LOCKED. oLocked rises on that clock.
  - LOCKED, any mismatch:
    - oError pulses on the detecting clock and oErrCount increments.
    - oLocked falls on the same clock and the state goes to ALIGN.
  - Any state, timeout: no hsync assert edge for 2*H_TOTAL strobes returns the state to SEARCH and drops oLocked. This is not counted as an error.
- Pixel output (LOCKED only):
  - Visible window: hcnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE) and vcnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE).
  - oPixelValid is 1 for exactly one clock per visible pixel, on the strobe clock.
  - oX = hcnt-(H_SYNC+H_BACK); oY = vcnt-(V_SYNC+V_BACK); oRGB = registered {R,G,B}.
  - Latency: 1 clock after the iVGA sample.
  - Outside LOCKED: oPixelValid is 0, and oX, oY, oRGB hold their last values.
- Lit count:
  - An internal counter increments on each oPixelValid with oRGB != 0.
  - At a vsync assert edge in LOCKED: oLitCount takes the counter value, the counter clears, and oFrameDone pulses.
  - Entering ALIGN or SEARCH clears the counter; oLitCount holds.
- Edge cases:
  - oErrCount saturates at 255.
  - A simultaneous hsync and vsync assert edge performs the vertical check first, then vcnt=0.
  - Reset mid-frame clears everything on the next clock edge.

Test Plan:
- Hold Reset for 5 clocks with random iVGA -> all outputs 0; oLocked stays 0 for the first partial frame after release.
- Nominal 640x480 generator, 2 clocks/pixel:
  - oLocked rises at the second vsync assert edge.
  - Frame 3: first oPixelValid has oX=0, oY=0, 1 clock after the sample at hcnt=144, vcnt=35.
  - 307200 valid pulses per frame.
- Single 801-pixel line during LOCKED -> oError pulses once, oErrCount=1, oLocked=0; relock after one clean frame.
- Hsync held deasserted -> SEARCH after 1600 strobes (3200 clocks); oLocked=0 and oErrCount unchanged.
- Image patterns:
  - All-white frame -> oLitCount=307200 with an oFrameDone pulse.
  - Checkerboard -> oLitCount=153600.
  - All-black -> oLitCount=0.
- Vsync width of 3 lines -> mismatch; no LOCKED while it persists; oErrCount saturates at 255 after 255 frames.
